// File: rtl/decode_token_if.sv
// Stream-side and token-side handshake bundle for the token decoder.
interface decode_token_if;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic [3:0]  stream_width;
    logic        stream_ack;
    logic        tok_valid;
    logic        tok_ready;
    logic        tok_match;
    logic [7:0]  tok_byte;
    logic [10:0] tok_offset;
    logic [11:0] tok_len;
    logic        tok_eob;

    modport master (
        output stream_data, stream_valid, tok_ready,
        input  stream_width, stream_ack, tok_valid, tok_match, tok_byte, tok_offset, tok_len,
               tok_eob
    );

    modport slave (
        input  stream_data, stream_valid, tok_ready,
        output stream_width, stream_ack, tok_valid, tok_match, tok_byte, tok_offset, tok_len,
               tok_eob
    );
endinterface

// File: rtl/decode_token.sv
// Decodes literal / match / end-marker tokens from a bit window and holds each
// decoded token in an output register until the copy engine accepts it.
module decode_token (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    decode_token_if.slave bus,
    output logic          len_err
);

    typedef enum logic [2:0] {StHead, StLen1, StLenx, StEmit, StStop} state_e;

    state_e      state_q, state_d;
    logic        match_q, match_d;
    logic [7:0]  byte_q, byte_d;
    logic [10:0] offset_q, offset_d;
    logic [11:0] len_q, len_d;
    logic        eob_q, eob_d;
    logic        err_q, err_d;

    logic        ack;
    logic [3:0]  width;
    logic        go;
    logic [12:0] d;
    logic [12:0] len_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StHead;
            match_q  <= 1'b0;
            byte_q   <= 8'd0;
            offset_q <= 11'd0;
            len_q    <= 12'd0;
            eob_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            byte_q   <= byte_d;
            offset_q <= offset_d;
            len_q    <= len_d;
            eob_q    <= eob_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        byte_d   = byte_q;
        offset_d = offset_q;
        len_d    = len_q;
        eob_d    = eob_q;
        err_d    = err_q;
        ack      = 1'b0;
        width    = 4'd0;
        d        = bus.stream_data;
        // rst gating keeps the handshake quiet while reset is held
        go       = ce && bus.stream_valid && !rst;
        len_sum  = {1'b0, len_q} + {9'd0, d[12:9]};

        case (state_q)
            StHead: begin
                if (go) begin
                    ack = 1'b1;
                    if (!d[12]) begin
                        match_d  = 1'b0;
                        byte_d   = d[11:4];
                        offset_d = 11'd0;
                        len_d    = 12'd0;
                        eob_d    = 1'b0;
                        width    = 4'd9;
                        state_d  = StEmit;
                    end else if (d[11]) begin
                        match_d  = 1'b1;
                        offset_d = {4'd0, d[10:4]};
                        len_d    = 12'd0;
                        width    = 4'd9;
                        if (d[10:4] == 7'd0) begin
                            eob_d   = 1'b1;
                            state_d = StEmit;
                        end else begin
                            eob_d   = 1'b0;
                            state_d = StLen1;
                        end
                    end else begin
                        match_d  = 1'b1;
                        offset_d = d[10:0];
                        len_d    = 12'd0;
                        eob_d    = 1'b0;
                        width    = 4'd13;
                        state_d  = StLen1;
                    end
                end
            end
            StLen1: begin
                if (go) begin
                    ack = 1'b1;
                    if (d[12:11] != 2'b11) begin
                        len_d   = 12'd2 + {10'd0, d[12:11]};
                        width   = 4'd2;
                        state_d = StEmit;
                    end else begin
                        // 1111 yields 8 and continues with extension nibbles
                        len_d   = 12'd5 + {10'd0, d[10:9]};
                        width   = 4'd4;
                        state_d = (d[10:9] == 2'b11) ? StLenx : StEmit;
                    end
                end
            end
            StLenx: begin
                if (go) begin
                    ack   = 1'b1;
                    width = 4'd4;
                    if (len_sum > 13'd4095) begin
                        len_d = 12'd4095;
                        err_d = 1'b1;
                    end else begin
                        len_d = len_sum[11:0];
                    end
                    state_d = (d[12:9] == 4'hf) ? StLenx : StEmit;
                end
            end
            StEmit: begin
                if (bus.tok_ready) begin
                    state_d = eob_q ? StStop : StHead;
                end
            end
            StStop: begin
                state_d = StStop;
            end
            default: begin
                state_d = StHead;
            end
        endcase
    end

    assign bus.stream_ack   = ack;
    assign bus.stream_width = width;
    assign bus.tok_valid    = (state_q == StEmit);
    assign bus.tok_match    = match_q;
    assign bus.tok_byte     = byte_q;
    assign bus.tok_offset   = offset_q;
    assign bus.tok_len      = len_q;
    assign bus.tok_eob      = eob_q;
    assign len_err          = err_q;

endmodule

// File: tb/tb_decode_token.sv
// Randomized bench for decode_token: encodes token streams from a high-level
// token list, feeds them through a bit-queue extractor and checks decoded tokens.
module tb_decode_token;

    typedef struct {
        bit        match;
        bit [7:0]  byt;
        bit [10:0] off;
        bit [11:0] len;
        bit        eob;
        bit        err;
    } tok_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    logic len_err;

    decode_token_if bus ();

    decode_token dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .bus     (bus),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    tok_t exp_q[$];
    bit   bits[$];
    int   wlog[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   exp_err    = 1'b0;
    bit   stopped    = 1'b0;
    int   pend_w     = 0;
    int   rdy_mode   = 1;   // 0 random, 1 forced high, 2 forced low
    int   rnd_mode   = 0;   // 1 randomizes ce and stream_valid gaps

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_bits(input int unsigned v, input int n);
        for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
    endtask

    task automatic push_exp(input bit m, input int b, input int off, input int len, input bit e);
        tok_t t;
        t.match = m;
        t.byt   = b[7:0];
        t.off   = off[10:0];
        t.len   = len[11:0];
        t.eob   = e;
        t.err   = exp_err;
        exp_q.push_back(t);
    endtask

    task automatic enc_lit(input int b);
        push_bits(0, 1);
        push_bits(b, 8);
        push_exp(1'b0, b, 0, 0, 1'b0);
    endtask

    task automatic enc_match(input int off, input int len, input bit long_form);
        int rem;
        if (!long_form && off >= 1 && off <= 127) begin
            push_bits(3, 2);
            push_bits(off, 7);
        end else begin
            push_bits(2, 2);
            push_bits(off, 11);
        end
        if (len <= 4) push_bits(len - 2, 2);
        else if (len <= 7) push_bits(12 + len - 5, 4);
        else begin
            push_bits(15, 4);
            rem = len - 8;
            while (rem >= 15) begin
                push_bits(15, 4);
                rem -= 15;
            end
            push_bits(rem, 4);
        end
        if (len > 4095) exp_err = 1'b1;
        push_exp(1'b1, 0, off, (len > 4095) ? 4095 : len, 1'b0);
    endtask

    task automatic enc_eob_pad();
        push_bits(3, 2);
        push_bits(0, 7);
        push_exp(1'b1, 0, 0, 0, 1'b1);
        push_bits(0, 16);
    endtask

    // Bit extractor: consume acked bits, then present the next 13-bit window.
    always @(posedge clk) begin
        #1;
        if (pend_w > 0) begin
            for (int i = 0; i < pend_w; i++) if (bits.size() > 0) void'(bits.pop_front());
            wlog.push_back(pend_w);
            pend_w = 0;
        end
        ce = (rnd_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.tok_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 :
                        ($urandom_range(0, 2) != 0);
        for (int i = 0; i < 13; i++) bus.stream_data[12-i] = (i < bits.size()) ? bits[i] : 1'b0;
        bus.stream_valid = (bits.size() >= 16) &&
                           ((rnd_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    always @(negedge clk) begin
        if (!rst) begin
            pend_w = bus.stream_ack ? int'(bus.stream_width) : 0;
            if (bus.stream_ack)
                check("ack_allowed", bus.stream_valid && ce && !bus.tok_valid && !stopped, 1);
            else
                check("width_idle", bus.stream_width, 0);
            if (bus.tok_valid) begin
                check("tok_pending", (exp_q.size() == 0) ? 0 : 1, 1);
                if (exp_q.size() > 0) begin
                    check("tok_match", bus.tok_match, exp_q[0].match);
                    check("tok_eob", bus.tok_eob, exp_q[0].eob);
                    if (exp_q[0].match) begin
                        check("tok_offset", bus.tok_offset, exp_q[0].off);
                        check("tok_len", bus.tok_len, exp_q[0].len);
                    end else begin
                        check("tok_byte", bus.tok_byte, exp_q[0].byt);
                    end
                    if (bus.tok_ready) begin
                        check("len_err", len_err, exp_q[0].err);
                        if (exp_q[0].eob) stopped = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int bound);
        int cyc = 0;
        while (!(stopped && exp_q.size() == 0) && cyc < bound) begin
            @(posedge clk);
            cyc++;
        end
        check("stop_reached", (stopped && exp_q.size() == 0) ? 1 : 0, 1);
        repeat (6) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bits.delete();
        exp_q.delete();
        exp_err = 1'b0;
        stopped = 1'b0;
        #1;
        check("rst_tok_valid", bus.tok_valid, 0);
        check("rst_ack", bus.stream_ack, 0);
        check("rst_width", bus.stream_width, 0);
        check("rst_match", bus.tok_match, 0);
        check("rst_eob", bus.tok_eob, 0);
        check("rst_byte", bus.tok_byte, 0);
        check("rst_offset", bus.tok_offset, 0);
        check("rst_len", bus.tok_len, 0);
        check("rst_len_err", len_err, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wlog.delete();
    endtask

    task automatic check_widths(input string name, input int w0, input int w1, input int w2,
                                input int w3, input int n);
        int exp_w[4];
        exp_w = '{w0, w1, w2, w3};
        check({name, "_count"}, wlog.size(), n + 1);
        for (int i = 0; i < n; i++) check(name, (i < wlog.size()) ? wlog[i] : -1, exp_w[i]);
    endtask

    initial begin
        int cyc;
        int len;
        bus.tok_ready    = 1'b1;
        bus.stream_valid = 1'b0;
        bus.stream_data  = 13'd0;
        repeat (2) @(posedge clk);
        do_reset();

        // Literal 0x41
        push_bits(9'h041, 9);
        push_exp(1'b0, 8'h41, 0, 0, 1'b0);
        enc_eob_pad();
        wait_idle(200);
        check_widths("w_lit", 9, 0, 0, 0, 1);
        do_reset();

        // Short-offset match: offset 5, length 3
        push_bits(9'h185, 9);
        push_bits(2'b01, 2);
        push_exp(1'b1, 0, 5, 3, 1'b0);
        enc_eob_pad();
        wait_idle(200);
        check_widths("w_short", 9, 2, 0, 0, 2);
        do_reset();

        // Long-offset match with extension: offset 16, length 25
        push_bits(2, 2);
        push_bits(16, 11);
        push_bits(15, 4);
        push_bits(15, 4);
        push_bits(2, 4);
        push_exp(1'b1, 0, 16, 25, 1'b0);
        enc_eob_pad();
        wait_idle(200);
        check_widths("w_long", 13, 4, 4, 4, 4);
        do_reset();

        // Lone end marker; no acks afterwards even with stream_valid high
        push_bits(9'h180, 9);
        push_exp(1'b1, 0, 0, 0, 1'b1);
        push_bits(0, 16);
        wait_idle(200);
        repeat (10) @(posedge clk);
        check_widths("w_eob", 9, 0, 0, 0, 0);
        do_reset();

        // Back-pressure on a pending literal
        rdy_mode = 2;
        enc_lit(8'h5a);
        enc_eob_pad();
        cyc = 0;
        while (!bus.tok_valid && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        check("stall_tok_valid", bus.tok_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_ack", bus.stream_ack, 0);
            check("stall_byte", bus.tok_byte, 8'h5a);
        end
        rdy_mode = 1;
        wait_idle(200);
        do_reset();

        // Reset while accumulating extension nibbles
        push_bits(2, 2);
        push_bits(100, 11);
        repeat (6) push_bits(15, 4);
        cyc = 0;
        while (wlog.size() < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("lenx_reached", wlog.size(), 3);
        do_reset();
        enc_lit(8'hc3);
        enc_eob_pad();
        wait_idle(200);
        do_reset();

        // Randomized token stream with gaps, back-pressure and one oversize length
        rdy_mode = 0;
        rnd_mode = 1;
        enc_match($urandom_range(1, 2047), 4100, $urandom_range(0, 1));
        for (int t = 0; t < 120; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: enc_lit($urandom_range(0, 255));
                default: begin
                    case ($urandom_range(0, 19))
                        0: len = $urandom_range(4090, 4200);
                        1, 2, 3, 4, 5: len = $urandom_range(9, 100);
                        default: len = $urandom_range(2, 8);
                    endcase
                    enc_match($urandom_range(1, 2047), len, $urandom_range(0, 1));
                end
            endcase
        end
        enc_eob_pad();
        wait_idle(50000);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
